// File: rtl/sr_pkg.sv
// Shared definitions for the SR flip-flop bank: illegal-input policy codes
// and the single-bit next-state rule.
package sr_pkg;

  localparam logic [1:0] SR_INV_HOLD   = 2'd0;
  localparam logic [1:0] SR_INV_SET    = 2'd1;
  localparam logic [1:0] SR_INV_CLR    = 2'd2;
  localparam logic [1:0] SR_INV_TOGGLE = 2'd3;

  function automatic logic sr_next(input logic s, input logic r, input logic q,
                                   input logic [1:0] mode);
    logic nxt;
    nxt = q;
    if (s && !r) begin
      nxt = 1'b1;
    end else if (!s && r) begin
      nxt = 1'b0;
    end else if (s && r) begin
      case (mode)
        SR_INV_SET:    nxt = 1'b1;
        SR_INV_CLR:    nxt = 1'b0;
        SR_INV_TOGGLE: nxt = ~q;
        default:       nxt = q;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sr_ff_bit.sv
// One SR storage bit: async-reset register, policy-driven next state and a
// one-cycle flag marking that s=r=1 was sampled.
module sr_ff_bit
  import sr_pkg::*;
#(
  parameter logic [1:0] MODE      = SR_INV_HOLD,
  parameter logic       RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  output logic q,
  output logic invalid
);

  logic q_next;

  always_comb begin
    q_next = sr_next(s, r, q, MODE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q       <= RESET_VAL;
      invalid <= 1'b0;
    end else begin
      q       <= q_next;
      invalid <= s & r;
    end
  end

endmodule

// File: rtl/sr_ff.sv
// Bank of WIDTH independent clocked SR flip-flops with true/complement outputs
// and a per-bit illegal-input flag.
module sr_ff
  import sr_pkg::*;
#(
  parameter int               WIDTH        = 1,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0,
  parameter int               INVALID_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] invalid
);

  localparam logic [1:0] MODE = 2'(INVALID_MODE);

  if (INVALID_MODE < 0 || INVALID_MODE > 3) begin : g_bad_mode
    $error("sr_ff: INVALID_MODE must be 0..3, got %0d", INVALID_MODE);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_ff_bit #(
      .MODE      (MODE),
      .RESET_VAL (RESET_VAL[i])
    ) u_bit (
      .clk     (clk),
      .reset   (reset),
      .s       (s[i]),
      .r       (r[i]),
      .q       (q[i]),
      .invalid (invalid[i])
    );
  end

  // Complement comes from the same flop, so q and q_bar can never agree.
  assign q_bar = ~q;

endmodule

// File: tb/tb_sr_ff.sv
// Self-checking bench for sr_ff: directed scenarios plus randomized s/r/reset
// traffic on five configurations against a vector-level reference model.
module tb_sr_ff;

  logic       clk = 1'b0;
  logic       reset;
  logic       s1, r1;
  logic [3:0] s4, r4;
  logic [1:0] s2, r2;

  logic       q1, qb1, iv1;
  logic [3:0] qa, qba, iva;
  logic [3:0] qc, qbc, ivc;
  logic [3:0] qt, qbt, ivt;
  logic [1:0] q2, qb2, iv2;

  // expected state
  logic       e1, ei1;
  logic [3:0] ea, ec, et, ei4;
  logic [1:0] e2, ei2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sr_ff u_d1 (.clk(clk), .reset(reset), .s(s1), .r(r1), .q(q1), .q_bar(qb1), .invalid(iv1));

  sr_ff #(.WIDTH(4), .INVALID_MODE(1)) u_set (
    .clk(clk), .reset(reset), .s(s4), .r(r4), .q(qa), .q_bar(qba), .invalid(iva));

  sr_ff #(.WIDTH(4), .INVALID_MODE(2)) u_clr (
    .clk(clk), .reset(reset), .s(s4), .r(r4), .q(qc), .q_bar(qbc), .invalid(ivc));

  sr_ff #(.WIDTH(4), .INVALID_MODE(3)) u_tog (
    .clk(clk), .reset(reset), .s(s4), .r(r4), .q(qt), .q_bar(qbt), .invalid(ivt));

  sr_ff #(.WIDTH(2), .RESET_VAL(2'b10)) u_w2 (
    .clk(clk), .reset(reset), .s(s2), .r(r2), .q(q2), .q_bar(qb2), .invalid(iv2));

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Vector-level rule: plain set/clear masks, then the illegal-input policy on s&r bits.
  function automatic logic [3:0] model(input int mode, input logic [3:0] s,
                                       input logic [3:0] r, input logic [3:0] q);
    logic [3:0] both, base;
    both = s & r;
    base = (q & ~(r & ~s)) | (s & ~r);
    case (mode)
      1:       return base | both;
      2:       return base & ~both;
      3:       return base ^ both;
      default: return base;
    endcase
  endfunction

  task automatic model_reset();
    e1 = 1'b0; ea = 4'h0; ec = 4'h0; et = 4'h0; e2 = 2'b10;
    ei1 = 1'b0; ei4 = 4'h0; ei2 = 2'b00;
  endtask

  task automatic model_edge();
    logic [3:0] t;
    if (reset) begin
      model_reset();
    end else begin
      t   = model(0, {3'b0, s1}, {3'b0, r1}, {3'b0, e1});
      e1  = t[0];
      ea  = model(1, s4, r4, ea);
      ec  = model(2, s4, r4, ec);
      et  = model(3, s4, r4, et);
      t   = model(0, {2'b0, s2}, {2'b0, r2}, {2'b0, e2});
      e2  = t[1:0];
      ei1 = s1 & r1;
      ei4 = s4 & r4;
      ei2 = s2 & r2;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":d1_q"},   {3'b0, q1},  {3'b0, e1});
    chk({tag, ":d1_qb"},  {3'b0, qb1}, {3'b0, ~e1});
    chk({tag, ":d1_inv"}, {3'b0, iv1}, {3'b0, ei1});
    chk({tag, ":m1_q"},   qa,  ea);
    chk({tag, ":m1_qb"},  qba, ~ea);
    chk({tag, ":m1_inv"}, iva, ei4);
    chk({tag, ":m2_q"},   qc,  ec);
    chk({tag, ":m2_qb"},  qbc, ~ec);
    chk({tag, ":m2_inv"}, ivc, ei4);
    chk({tag, ":m3_q"},   qt,  et);
    chk({tag, ":m3_qb"},  qbt, ~et);
    chk({tag, ":m3_inv"}, ivt, ei4);
    chk({tag, ":w2_q"},   {2'b0, q2},  {2'b0, e2});
    chk({tag, ":w2_qb"},  {2'b0, qb2}, {2'b0, ~e2});
    chk({tag, ":w2_inv"}, {2'b0, iv2}, {2'b0, ei2});
  endtask

  // Edge, then update the model and sample 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic a1, input logic b1, input logic [3:0] a4,
                       input logic [3:0] b4, input logic [1:0] a2, input logic [1:0] b2);
    s1 = a1; r1 = b1; s4 = a4; r4 = b4; s2 = a2; r2 = b2;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 2'b00);
    model_reset();
    #2;
    check_all("async_rst");
    chk("w2_rstval", {2'b0, q2}, 4'b0010);
    chk("w2_rstval_qb", {2'b0, qb2}, 4'b0001);
    step("rst_held");
    step("rst_held2");

    reset = 1'b0;
    step("hold_after_rel");
    chk("d1_hold_zero", {3'b0, q1}, 4'b0000);

    drive(1'b1, 1'b0, 4'b0101, 4'b1010, 2'b01, 2'b10);
    step("set_load");
    chk("d1_set", {3'b0, q1}, 4'b0001);
    chk("m3_load", qt, 4'b0101);
    chk("w2_load", {2'b0, q2}, 4'b0001);

    drive(1'b0, 1'b0, 4'b1111, 4'b1111, 2'b00, 2'b00);
    step("illegal4");
    chk("m3_toggle", qt, 4'b1010);
    chk("m1_setdom", qa, 4'b1111);
    chk("m2_clrdom", qc, 4'b0000);
    chk("m3_inv_all", ivt, 4'b1111);
    chk("d1_hold_one", {3'b0, q1}, 4'b0001);

    drive(1'b1, 1'b1, 4'b0011, 4'b1100, 2'b00, 2'b00);
    step("illegal1");
    chk("d1_illegal_hold", {3'b0, q1}, 4'b0001);
    chk("d1_inv_flag", {3'b0, iv1}, 4'b0001);
    chk("m3_mixed", qt, 4'b0011);
    chk("m3_inv_clear", ivt, 4'b0000);

    drive(1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 2'b00);
    step("inv_drop");
    chk("d1_inv_drop", {3'b0, iv1}, 4'b0000);

    drive(1'b0, 1'b1, 4'h0, 4'h0, 2'b00, 2'b00);
    step("clear");
    chk("d1_clear", {3'b0, q1}, 4'b0000);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 2'b00, 2'b00);
    step("hold0");

    drive(1'b1, 1'b0, 4'hF, 4'h0, 2'b11, 2'b00);
    step("preset");
    // mid-cycle reset with s still asserted
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("midcyc_rst");
    chk("d1_midcyc_rst", {3'b0, q1}, 4'b0000);
    step("rst_vs_set");
    #2;
    reset = 1'b0;

    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
            2'($urandom), 2'($urandom));
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        check_all("rnd_rst");
        step("rnd_rst_edge");
        #2;
        reset = 1'b0;
      end else begin
        step("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
